mcp3202_spi_master: RTL and testbench
=====================================

Name: mcp3202_spi_master

Overview:
- Synthesizable SPI initiator for the MCP3202 12-bit ADC, SPI mode 0,0. It runs the front-end sample clock for the ECG acquisition chain.
- Issues one conversion per sample period on a runtime-selectable channel/mode, captures the 12-bit result and presents it with a one-cycle valid strobe.
- Sits between the ADC pins and the downstream filter/decimation path. It is the counterpart of the bench ADC responder model.

Parameters:
- FCLK, 100e6: system clock frequency in Hz; legal 10e6 to 200e6.
- FSCK, 500e3: SCK frequency in Hz; legal 10e3 to 900e3.
- FS, 500: sample rate in Hz; one conversion per 1/FS.
- MSBF, 1: value sent in the MSBF command bit. Only 1 is supported; LSB-first trailer is not read.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- en  in  1  1 = conversions run; sampled at each sample tick
- sgl  in  1  SGL/DIFF command bit; latched at frame start
- odd  in  1  ODD/SIGN command bit; latched at frame start
- miso  in  1  ADC DOUT
- mosi  out  1  ADC DIN
- sck  out  1  SPI clock, idles low
- cs  out  1  ADC chip select, active low
- data  out  12  last captured sample
- data_ch  out  1  odd value used for the sample in data
- dv  out  1  one-cycle data-valid strobe
- busy  out  1  high from cs fall until cs rise

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Derived constants (integer, computed at elaboration):
  - HALF = FCLK/(2*FSCK).
  - TS = FCLK/FS.
  - CSH = ceil(500e-9*FCLK).
  - Elaboration error if HALF*1e9/FCLK < 100 or TS < 36*HALF+CSH.
- Reset values, applied every cycle rst_n=0 is sampled, including mid-frame:
  - cs=1, sck=0, mosi=0, dv=0, busy=0, data=0, data_ch=0.
  - State IDLE; sample timer loaded with CSH.
- Sample timer:
  - Counts down every cycle.
  - At 0 it produces a tick and reloads TS-1.
  - Tick with en=1 in IDLE starts a frame.
  - Tick while busy or with en=0 is discarded; no catch-up.
- FSM IDLE -> SETUP -> SHIFT -> DONE -> IDLE.
  - IDLE: cs=1, sck=0, mosi=0.
  - SETUP:
    - Cycle of entry: cs=0, busy=1, sgl/odd latched, mosi=1 (start bit).
    - Holds HALF cycles; guarantees TSUCS >= 100 ns before the first sck rise.
  - SHIFT: 17 SCK periods, each HALF cycles high then HALF cycles low.
    - mosi changes only on sck falling edges. Sequence per rise: rise1 start=1, rise2 sgl, rise3 odd, rise4 MSBF; mosi=0 from the fall after rise4.
    - miso sampled in the clk cycle of each sck rise.
    - Rise5 = null bit, discarded, no check.
    - Rises 6..17 shift B11..B0 MSB-first into a 12-bit shift register.
  - DONE: entered on the 17th sck fall (sck=0).
    - Next cycle: cs=1, busy=0, data<=shift register, data_ch<=latched odd, dv=1 for exactly that one cycle.
    - Returns to IDLE.
- Frame length is 35*HALF+1 cycles; the next cs fall is TS cycles after the previous one.
- cs high time is always >= CSH cycles, including the first frame after reset.
- en deasserted mid-frame: the frame completes and dv still pulses; no further frames start.
- sgl/odd changes mid-frame: no effect until the next frame.
- data holds between dv pulses; unknown miso captured as-is.

Test Plan:
- Defaults (HALF=100, TS=200000), en=1, sgl=1, odd=0, responder returns 0x75F:
  - mosi at rises 1-4 = 1,1,0,1; sck period 2000 ns; TSUCS >= 1000 ns.
  - data=0x75F with dv=1 in the first cs-high cycle; data_ch=0.
- Three back-to-back frames with samples 0x4E8, 0x01A, 0xFFF:
  - each captured exactly; cs fall-to-fall spacing exactly 2 ms.
  - exactly one dv per frame; dv high exactly 1 cycle.
- sgl=0, odd=1:
  - command bits 1,0,1,1; data_ch=1.
  - change odd to 0 mid-frame: current frame is unaffected, next frame sends odd=0.
- en=0 from reset for 5 ms -> cs stays 1, sck stays 0, dv never asserts.
  - Drop en at sck rise 8 -> frame completes, dv pulses once, no further cs fall.
- Assert rst_n=0 at sck rise 10 -> next cycle cs=1, sck=0, data=0, dv=0.
  - After release: first cs fall occurs CSH (=50) cycles later, and the full frame is correct.
- Boundary samples 0x000 and 0x800 -> captured exactly; an all-ones miso gives 0xFFF.

Source files
------------

// File: rtl/mcp3202_spi_master.sv
// MCP3202 SPI mode-0 initiator: one conversion per sample period.
// Captures the 12-bit result and strobes dv for one cycle.
module mcp3202_spi_master #(
    parameter int unsigned FCLK = 100_000_000,
    parameter int unsigned FSCK = 500_000,
    parameter int unsigned FS   = 500,
    parameter int unsigned MSBF = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        sgl,
    input  logic        odd,
    input  logic        miso,
    output logic        mosi,
    output logic        sck,
    output logic        cs,
    output logic [11:0] data,
    output logic        data_ch,
    output logic        dv,
    output logic        busy
);

    localparam int unsigned HALF = FCLK / (2 * FSCK);
    localparam int unsigned TS   = FCLK / FS;
    localparam int unsigned CSH  = (FCLK + 1_999_999) / 2_000_000;
    localparam longint unsigned HALF_NS =
        (64'(HALF) * 64'd1_000_000_000) / 64'(FCLK);
    localparam int CW = $clog2(HALF + 1);
    localparam int TW = $clog2(TS + 1);

    if (HALF_NS < 64'd100) begin : g_bad_half
        $error("SCK half period shorter than 100 ns");
    end
    if (TS < 36 * HALF + CSH) begin : g_bad_ts
        $error("sample period too short for one frame");
    end
    if (MSBF != 1) begin : g_bad_msbf
        $error("only MSB-first readout is supported");
    end

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic          sgl_q, sgl_d;
    logic          odd_q, odd_d;
    logic [11:0]   sr_q, sr_d;
    logic          cs_q, cs_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          dv_q, dv_d;
    logic          busy_q, busy_d;
    logic [11:0]   data_q, data_d;
    logic          data_ch_q, data_ch_d;

    logic tick;
    logic half_end;
    logic last_low;
    logic rise;
    logic fall;

    assign tick     = (tmr_q == '0);
    assign half_end = (cnt_q == '0);
    assign last_low = (bit_q == 5'd17) && !sck_q;

    // rise/fall mark the clk cycle in which sck toggles
    assign rise = half_end &&
                  ((state_q == SETUP) ||
                   ((state_q == SHIFT) && !sck_q && !last_low));
    assign fall = half_end && (state_q == SHIFT) && sck_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tmr_q     <= TW'(CSH);
            cnt_q     <= '0;
            bit_q     <= '0;
            sgl_q     <= 1'b0;
            odd_q     <= 1'b0;
            sr_q      <= '0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= '0;
            data_ch_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sgl_q     <= sgl_d;
            odd_q     <= odd_d;
            sr_q      <= sr_d;
            cs_q      <= cs_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            data_ch_q <= data_ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tmr_d   = tick ? TW'(TS - 1) : tmr_q - 1'b1;
        unique case (state_q)
            IDLE: begin
                if (tick && en) begin
                    state_d = SETUP;
                    cnt_d   = CW'(HALF - 1);
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (half_end) begin
                    state_d = SHIFT;
                    cnt_d   = CW'(HALF - 1);
                    bit_d   = 5'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                if (!half_end) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = CW'(HALF - 1);
                    if (last_low) begin
                        state_d = DONE;
                    end else if (!sck_q) begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cs_d      = cs_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        dv_d      = 1'b0;
        data_d    = data_q;
        data_ch_d = data_ch_q;
        sr_d      = sr_q;
        sgl_d     = sgl_q;
        odd_d     = odd_q;
        unique case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                sck_d  = 1'b0;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (tick && en) begin
                    cs_d   = 1'b0;
                    busy_d = 1'b1;
                    mosi_d = 1'b1;
                    sgl_d  = sgl;
                    odd_d  = odd;
                end
            end
            SETUP, SHIFT: begin
                if (rise) begin
                    sck_d = 1'b1;
                    // rises 6..17 carry B11..B0
                    if (bit_q >= 5'd5) begin
                        sr_d = {sr_q[10:0], miso};
                    end
                end
                if (fall) begin
                    sck_d = 1'b0;
                    case (bit_q)
                        5'd1:    mosi_d = sgl_q;
                        5'd2:    mosi_d = odd_q;
                        5'd3:    mosi_d = 1'(MSBF);
                        default: mosi_d = 1'b0;
                    endcase
                end
            end
            DONE: begin
                cs_d      = 1'b1;
                sck_d     = 1'b0;
                mosi_d    = 1'b0;
                busy_d    = 1'b0;
                dv_d      = 1'b1;
                data_d    = sr_q;
                data_ch_d = odd_q;
            end
            default: begin
                cs_d   = 1'b1;
                sck_d  = 1'b0;
                mosi_d = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign mosi    = mosi_q;
    assign sck     = sck_q;
    assign cs      = cs_q;
    assign data    = data_q;
    assign data_ch = data_ch_q;
    assign dv      = dv_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mcp3202_spi_master.sv
// Bench for mcp3202_spi_master with an MCP3202 responder model.
// Scaled clocks: HALF=20 cycles, TS=1000 cycles, CSH=10 cycles.
`timescale 1ns/1ps
module tb_mcp3202_spi_master;

    localparam int HALF = 20;
    localparam int TS   = 1000;
    localparam int CSH  = 10;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sgl;
    logic        odd;
    logic        miso;
    logic        mosi;
    logic        sck;
    logic        cs;
    logic [11:0] data;
    logic        data_ch;
    logic        dv;
    logic        busy;

    int checks;
    int failures;

    mcp3202_spi_master #(
        .FCLK(20_000_000),
        .FSCK(500_000),
        .FS  (20_000),
        .MSBF(1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .sgl    (sgl),
        .odd    (odd),
        .miso   (miso),
        .mosi   (mosi),
        .sck    (sck),
        .cs     (cs),
        .data   (data),
        .data_ch(data_ch),
        .dv     (dv),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    // responder / monitor state
    logic        prev_cs   = 1'b1;
    logic        prev_sck  = 1'b0;
    logic        prev_dv   = 1'b0;
    logic        prev_mosi = 1'b0;
    logic        ones      = 1'b0;
    logic [11:0] next_samp = '0;
    logic [11:0] cur_samp  = '0;
    logic [3:0]  cmd       = '0;
    int cyc       = 0;
    int fall_cyc  = 0;
    int spacing   = 0;
    int rise_n    = 0;
    int fall_n    = 0;
    int rise1_cyc = 0;
    int rise2_cyc = 0;
    int frame_len = 0;
    int ncs_fall  = 0;
    int nsck_rise = 0;
    int dv_n      = 0;
    int dv_long   = 0;
    int mosi_bad  = 0;

    initial miso = 1'b0;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_cs   <= cs;
        prev_sck  <= sck;
        prev_dv   <= dv;
        prev_mosi <= mosi;
        if (prev_cs && !cs) begin
            cur_samp <= next_samp;
            rise_n   <= 0;
            fall_n   <= 0;
            cmd      <= '0;
            spacing  <= cyc - fall_cyc;
            fall_cyc <= cyc;
            ncs_fall <= ncs_fall + 1;
            miso     <= ones | 1'($urandom);
        end
        if (!prev_cs && cs) frame_len <= cyc - fall_cyc;
        if (!prev_sck && sck) begin
            nsck_rise <= nsck_rise + 1;
            if (!cs) begin
                rise_n <= rise_n + 1;
                if (rise_n < 4) cmd <= {cmd[2:0], mosi};
                if (rise_n == 0) rise1_cyc <= cyc;
                if (rise_n == 1) rise2_cyc <= cyc;
            end
        end
        if (prev_sck && !sck && !cs) begin
            fall_n <= fall_n + 1;
            if (fall_n >= 4 && fall_n <= 15)
                miso <= ones | cur_samp[4'(15 - fall_n)];
            else
                miso <= ones | 1'($urandom);
        end
        if (dv) dv_n <= dv_n + 1;
        if (dv && prev_dv) dv_long <= dv_long + 1;
        if ((mosi != prev_mosi) && !(prev_sck && !sck) && (prev_cs == cs))
            mosi_bad <= mosi_bad + 1;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic finish_frame(input logic [11:0] ed, input logic ec,
                                input logic [3:0] ecmd, input logic sp);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * TS; i++) begin
            @(negedge clk);
            if (dv) begin
                ok = 1'b1;
                break;
            end
        end
        chk("dv_seen", 32'(ok), 32'd1);
        if (ok) begin
            chk("data", 32'(data), 32'(ed));
            chk("data_ch", 32'(data_ch), 32'(ec));
            chk("cs_at_dv", 32'(cs), 32'd1);
            chk("busy_at_dv", 32'(busy), 32'd0);
            @(negedge clk);
            chk("dv_width", 32'(dv), 32'd0);
            #1;
            chk("cmd_bits", 32'(cmd), 32'(ecmd));
            chk("frame_len", 32'(frame_len), 32'(35 * HALF + 1));
            chk("tsucs", 32'(rise1_cyc - fall_cyc), 32'(HALF));
            chk("sck_period", 32'(rise2_cyc - rise1_cyc), 32'(2 * HALF));
            if (sp) chk("cs_spacing", 32'(spacing), 32'(TS));
        end
    endtask

    task automatic wait_rise(input int r);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * TS; i++) begin
            @(negedge clk);
            #1;
            if (!cs && rise_n == r) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_rise", 32'(ok), 32'd1);
    endtask

    task automatic count_to_cs_fall(input string nm);
        int n;
        n = 0;
        for (int i = 0; i < 2 * TS; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!cs) break;
        end
        chk(nm, 32'(n), 32'(CSH + 1));
    endtask

    typedef struct packed {
        logic        s;
        logic        o;
        logic        on;
        logic [11:0] samp;
        logic [11:0] exp_d;
        logic        exp_c;
        logic [3:0]  exp_cmd;
    } vec_t;

    vec_t tbl [8];
    int   base_dv;
    int   base_cs;
    logic rs;
    logic ro;
    logic [11:0] rsamp;

    initial begin
        checks   = 0;
        failures = 0;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 12'h75F, 12'h75F, 1'b0, 4'b1101};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 12'h4E8, 12'h4E8, 1'b0, 4'b1101};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 12'h01A, 12'h01A, 1'b0, 4'b1101};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 12'hFFF, 12'hFFF, 1'b0, 4'b1101};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 12'h5A3, 12'h5A3, 1'b1, 4'b1011};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 4'b1111};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 12'h800, 12'h800, 1'b0, 4'b1001};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 12'h000, 12'hFFF, 1'b0, 4'b1101};

        rst_n = 1'b0;
        en    = 1'b0;
        sgl   = 1'b0;
        odd   = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_dv", 32'(dv), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_data_ch", 32'(data_ch), 32'd0);

        // en low from reset: nothing may happen
        rst_n = 1'b1;
        repeat (3 * TS) @(negedge clk);
        #1;
        chk("idle_cs_falls", 32'(ncs_fall), 32'd0);
        chk("idle_sck_rises", 32'(nsck_rise), 32'd0);
        chk("idle_dv", 32'(dv_n), 32'd0);
        chk("idle_cs", 32'(cs), 32'd1);

        @(negedge clk);
        rst_n     = 1'b0;
        en        = 1'b1;
        sgl       = tbl[0].s;
        odd       = tbl[0].o;
        ones      = tbl[0].on;
        next_samp = tbl[0].samp;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_to_cs_fall("first_cs_fall");

        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                sgl       = tbl[i].s;
                odd       = tbl[i].o;
                ones      = tbl[i].on;
                next_samp = tbl[i].samp;
            end
            finish_frame(tbl[i].exp_d, tbl[i].exp_c, tbl[i].exp_cmd, i > 0);
        end
        ones = 1'b0;

        // odd changes after rise 2: current frame keeps the latched value
        sgl       = 1'b0;
        odd       = 1'b1;
        next_samp = 12'h3C6;
        wait_rise(2);
        odd       = 1'b0;
        finish_frame(12'h3C6, 1'b1, 4'b1011, 1'b1);
        next_samp = 12'hA55;
        finish_frame(12'hA55, 1'b0, 4'b1001, 1'b1);

        // en dropped at rise 8: frame finishes, then silence
        sgl       = 1'b1;
        next_samp = 12'h2B7;
        base_dv   = dv_n;
        wait_rise(8);
        en = 1'b0;
        finish_frame(12'h2B7, 1'b0, 4'b1101, 1'b1);
        chk("en_drop_dv_once", 32'(dv_n - base_dv), 32'd1);
        base_cs = ncs_fall;
        base_dv = dv_n;
        repeat (3 * TS) @(negedge clk);
        #1;
        chk("en_drop_no_cs", 32'(ncs_fall - base_cs), 32'd0);
        chk("en_drop_no_dv", 32'(dv_n - base_dv), 32'd0);

        // reset at rise 10
        en        = 1'b1;
        next_samp = 12'h6D1;
        wait_rise(10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_cs", 32'(cs), 32'd1);
        chk("midrst_sck", 32'(sck), 32'd0);
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_dv", 32'(dv), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        sgl       = 1'b0;
        odd       = 1'b1;
        next_samp = 12'h19E;
        count_to_cs_fall("cs_fall_after_rst");
        finish_frame(12'h19E, 1'b1, 4'b1011, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rs        = 1'($urandom);
            ro        = 1'($urandom);
            rsamp     = 12'($urandom_range(0, 4095));
            sgl       = rs;
            odd       = ro;
            next_samp = rsamp;
            finish_frame(rsamp, ro, {1'b1, rs, ro, 1'b1}, 1'b1);
        end

        chk("dv_single_cycle", 32'(dv_long), 32'd0);
        chk("mosi_only_on_fall", 32'(mosi_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
